// File: rtl/dma_bus_throttle_pkg.sv
// Shared definitions for the DMA bus throttle: FSM encoding, config register selects, reset defaults.
package dma_bus_throttle_pkg;

    localparam int unsigned CFG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam logic [1:0] CFG_BURST = 2'd0;
    localparam logic [1:0] CFG_GAP   = 2'd1;
    localparam logic [1:0] CFG_THR   = 2'd2;
    localparam logic [1:0] CFG_STAT  = 2'd3;

    localparam logic [CFG_W-1:0] DEF_BURST_LEN = 8'd16;
    localparam logic [CFG_W-1:0] DEF_GAP_LEN   = 8'd4;

endpackage

// File: rtl/dma_bus_throttle.sv
// Gates the dma_sequencer req/ack/end handshake into bursts of burst_len accepts,
// separated by gap_len idle cycles once all outstanding transfers have ended.
module dma_bus_throttle
    import dma_bus_throttle_pkg::*;
#(
    parameter logic [7:0] BURST_DEF = DEF_BURST_LEN,
    parameter logic [7:0] GAP_DEF   = DEF_GAP_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_req,
    output logic       up_ack,
    output logic       up_end,
    output logic       dn_req,
    input  logic       dn_ack,
    input  logic       dn_end,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_sel,
    input  logic [7:0] cfg_din,
    output logic [7:0] cfg_dout
);

    state_e     state_q, state_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [7:0] gcnt_q, gcnt_d;
    logic [7:0] thr_q, thr_d;
    logic [7:0] burst_len_q, burst_len_d;
    logic [7:0] gap_len_q, gap_len_d;
    logic [1:0] outst_q, outst_d;
    logic       limit_hit;

    // Handshake gating is purely combinational so a reset drops dn_req immediately.
    assign dn_req = (state_q == ST_BURST) && up_req;
    assign up_ack = dn_ack && dn_req;
    assign up_end = dn_end;

    // >= rather than == so a burst_len lowered below bcnt mid-burst ends at the next accept.
    assign limit_hit = (burst_len_q != 8'd0) && up_ack &&
                       (({1'b0, bcnt_q} + 9'd1) >= {1'b0, burst_len_q});

    always_comb begin
        outst_d = outst_q;
        if (up_ack && !dn_end && (outst_q != 2'd3)) begin
            outst_d = outst_q + 2'd1;
        end else if (dn_end && !up_ack && (outst_q != 2'd0)) begin
            outst_d = outst_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (up_req) begin
                    state_d = ST_BURST;
                    bcnt_d  = 8'd0;
                end
            end
            ST_BURST: begin
                if (up_ack) begin
                    bcnt_d = bcnt_q + 8'd1;
                end
                if (limit_hit) begin
                    state_d = ST_DRAIN;
                end else if (!up_req && (outst_q == 2'd0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (outst_q == 2'd0) begin
                    if (gap_len_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_len_q;
                    end
                end
            end
            ST_GAP: begin
                gcnt_d = gcnt_q - 8'd1;
                if (gcnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config registers; a throttle_cnt clear wins over a same-cycle limit increment.
    always_comb begin
        burst_len_d = burst_len_q;
        gap_len_d   = gap_len_q;
        thr_d       = thr_q;
        if (limit_hit && (thr_q != 8'hFF)) begin
            thr_d = thr_q + 8'd1;
        end
        if (cfg_wr) begin
            case (cfg_sel)
                CFG_BURST: burst_len_d = cfg_din;
                CFG_GAP:   gap_len_d   = cfg_din;
                CFG_THR:   thr_d       = 8'd0;
                default:   ;
            endcase
        end
    end

    always_comb begin
        cfg_dout = 8'd0;
        case (cfg_sel)
            CFG_BURST: cfg_dout = burst_len_q;
            CFG_GAP:   cfg_dout = gap_len_q;
            CFG_THR:   cfg_dout = thr_q;
            default:   cfg_dout = {state_q, outst_q, 3'b000, up_req};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= 8'd0;
            gcnt_q      <= 8'd0;
            thr_q       <= 8'd0;
            outst_q     <= 2'd0;
            burst_len_q <= BURST_DEF;
            gap_len_q   <= GAP_DEF;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            thr_q       <= thr_d;
            outst_q     <= outst_d;
            burst_len_q <= burst_len_d;
            gap_len_q   <= gap_len_d;
        end
    end

endmodule

// File: tb/tb_dma_bus_throttle.sv
// Scoreboard bench for dma_bus_throttle: randomized handshake/config traffic against a
// behavioural model of the burst/drain/gap policy, with a bench-side dma_access responder.
module tb_dma_bus_throttle;

    logic       clk;
    logic       rst_n;
    logic       up_req;
    logic       up_ack;
    logic       up_end;
    logic       dn_req;
    logic       dn_ack;
    logic       dn_end;
    logic       cfg_wr;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_din;
    logic [7:0] cfg_dout;

    dma_bus_throttle dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_req   (up_req),
        .up_ack   (up_ack),
        .up_end   (up_end),
        .dn_req   (dn_req),
        .dn_ack   (dn_ack),
        .dn_end   (dn_end),
        .cfg_wr   (cfg_wr),
        .cfg_sel  (cfg_sel),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dn_req;
        logic       up_ack;
        logic       up_end;
        logic [7:0] dout;
        int         cyc;
    } exp_t;

    typedef enum {P_IDLE, P_BURST, P_DRAIN, P_GAP} phase_t;

    exp_t   exp_q[$];
    int     pend_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     dly_min  = 2;
    int     dly_max  = 2;

    // Reference model: where the throttle is in its burst/gap cycle and what it has counted.
    phase_t m_phase;
    int     m_cnt, m_inflight, m_gap_left, m_blen, m_glen, m_thr;

    function automatic int phase_code(phase_t p);
        case (p)
            P_IDLE:  return 0;
            P_BURST: return 1;
            P_DRAIN: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_cnt      = 0;
        m_inflight = 0;
        m_gap_left = 0;
        m_blen     = 16;
        m_glen     = 4;
        m_thr      = 0;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int   rd;
        e.dn_req = (m_phase == P_BURST) && up_req;
        e.up_ack = e.dn_req && dn_ack;
        e.up_end = dn_end;
        case (cfg_sel)
            2'd0:    rd = m_blen;
            2'd1:    rd = m_glen;
            2'd2:    rd = m_thr;
            default: rd = phase_code(m_phase) * 64 + m_inflight * 16 + (up_req ? 1 : 0);
        endcase
        e.dout = 8'(rd);
        e.cyc  = cyc;
        return e;
    endfunction

    task automatic model_advance(input logic ack);
        int infl_old;
        infl_old = m_inflight;
        if (ack && !dn_end && m_inflight < 3)       m_inflight++;
        else if (dn_end && !ack && m_inflight > 0)  m_inflight--;
        case (m_phase)
            P_IDLE: if (up_req) begin
                m_phase = P_BURST;
                m_cnt   = 0;
            end
            P_BURST: begin
                if (ack) begin
                    if (m_blen != 0 && m_cnt + 1 >= m_blen) begin
                        m_phase = P_DRAIN;
                        if (m_thr < 255) m_thr++;
                    end
                    m_cnt = (m_cnt + 1) % 256;
                end else if (!up_req && infl_old == 0) begin
                    m_phase = P_IDLE;
                end
            end
            P_DRAIN: if (infl_old == 0) begin
                if (m_glen == 0) m_phase = P_IDLE;
                else begin
                    m_phase    = P_GAP;
                    m_gap_left = m_glen;
                end
            end
            default: begin
                if (m_gap_left == 1) m_phase = P_IDLE;
                m_gap_left--;
            end
        endcase
        if (cfg_wr) begin
            case (cfg_sel)
                2'd0:    m_blen = int'(cfg_din);
                2'd1:    m_glen = int'(cfg_din);
                2'd2:    m_thr  = 0;
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus: drive inputs after the edge, push the expected outputs.
    task automatic drive(input logic r_n, input logic req, input logic ack, input logic spur,
                         input logic wr, input logic [1:0] sel, input logic [7:0] din);
        exp_t e;
        logic endp;
        @(posedge clk);
        #1;
        cyc++;
        endp = 1'b0;
        if (r_n) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                if (pend_q[i] <= cyc) begin
                    pend_q.delete(i);
                    endp = 1'b1;
                    break;
                end
            end
            endp = endp | spur;
        end
        rst_n   = r_n;
        up_req  = req;
        dn_ack  = ack;
        dn_end  = endp;
        cfg_wr  = wr;
        cfg_sel = sel;
        cfg_din = din;
        if (!r_n) begin
            model_reset();
            pend_q.delete();
        end
        e = model_expect();
        exp_q.push_back(e);
        if (r_n) begin
            model_advance(e.up_ack);
            if (e.up_ack) pend_q.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] din);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sel, din);
    endtask

    task automatic run_phase(input int n, input int req_pct, input int ack_mode,
                             input int wr_pct, input int wr_sel, input int spur_pct);
        for (int i = 0; i < n; i++) begin
            logic       req, ack, wr, spur;
            logic [1:0] sel;
            logic [7:0] din;
            req  = int'($urandom_range(99, 0)) < req_pct;
            ack  = (ack_mode == 1) ? i[0] : (int'($urandom_range(99, 0)) < 60);
            wr   = int'($urandom_range(99, 0)) < wr_pct;
            sel  = 2'($urandom_range(3, 0));
            if (wr && wr_sel >= 0) sel = 2'(wr_sel);
            din  = (sel == 2'd0) ? 8'($urandom_range(6, 0)) : 8'($urandom_range(5, 0));
            spur = int'($urandom_range(99, 0)) < spur_pct;
            drive(1'b1, req, ack, spur, wr, sel, din);
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v,
                         input int c);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp_v);
        end
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dn_req",   {7'b0, dn_req}, {7'b0, e.dn_req}, e.cyc);
                check("up_ack",   {7'b0, up_ack}, {7'b0, e.up_ack}, e.cyc);
                check("up_end",   {7'b0, up_end}, {7'b0, e.up_end}, e.cyc);
                check("cfg_dout", cfg_dout,       e.dout,           e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; up_req = 1'b0; dn_ack = 1'b0; dn_end = 1'b0;
        cfg_wr = 1'b0; cfg_sel = 2'd0; cfg_din = 8'd0;
        model_reset();

        for (int s = 0; s < 4; s++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(s), 8'd0);
        for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s), 8'd0);

        // burst 4, gap 3, continuous request, ack every other cycle, end two cycles later
        dly_min = 2; dly_max = 2;
        cfg_write(2'd0, 8'd4);
        cfg_write(2'd1, 8'd3);
        run_phase(60, 100, 1, 0, -1, 0);

        // unlimited bursts never throttle
        cfg_write(2'd2, 8'd0);
        cfg_write(2'd0, 8'd0);
        dly_min = 1; dly_max = 3;
        run_phase(200, 100, 0, 0, -1, 0);

        // burst 8 with an intermittent requester
        cfg_write(2'd0, 8'd8);
        cfg_write(2'd1, 8'd4);
        run_phase(200, 45, 0, 0, -1, 0);

        // gap 0, burst 2, frequent throttle_cnt clears racing limit hits
        cfg_write(2'd0, 8'd2);
        cfg_write(2'd1, 8'd0);
        dly_min = 1; dly_max = 2;
        run_phase(200, 90, 0, 30, 2, 0);

        // everything random, including config rewrites mid-burst and stray end pulses
        dly_min = 1; dly_max = 5;
        run_phase(2000, 70, 0, 8, -1, 3);

        // reset asserted mid-burst with two transfers outstanding
        for (int k = 0; k < 80 && m_phase != P_IDLE; k++)
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom_range(3, 0)), 8'd0);
        dly_min = 30; dly_max = 30;
        cfg_write(2'd0, 8'd16);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s), 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_bus_throttle.md
DMA_BUS_THROTTLE -- requirements
Module: dma_bus_throttle

Interface
REQ-001 Parameter BURST_DEF, 8'd16: reset value of the burst-length register; 0 means unlimited.
REQ-002 Parameter GAP_DEF, 8'd4: reset value of the gap-length register, in clk cycles.
REQ-003 clk  in  1  clk_fpga domain, rising edge; the block's only clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 up_req  in  1  request from dma_sequencer (its dma_req).
REQ-006 up_ack  out  1  accept to dma_sequencer.
REQ-007 up_end  out  1  transfer-end pulse to dma_sequencer.
REQ-008 dn_req  out  1  gated request to dma_access.
REQ-009 dn_ack  in  1  accept from dma_access.
REQ-010 dn_end  in  1  end pulse from dma_access.
REQ-011 cfg_wr  in  1  one-cycle write strobe from ports.
REQ-012 cfg_sel  in  2  register select: 0 burst_len, 1 gap_len, 2 throttle_cnt (clear on write), 3 status.
REQ-013 cfg_din  in  8  write data.
REQ-014 cfg_dout  out  8  combinational read data for the cfg_sel register.

Function
REQ-015 dma_sequencer's addr/rnw/wd/rd SHALL bypass the block; it gates only req/ack/end.
REQ-016 FSM states SHALL be IDLE, BURST, DRAIN, GAP; encoding 2 bits, IDLE=0, BURST=1, DRAIN=2, GAP=3.
REQ-017 dn_req SHALL equal up_req in BURST and 0 in every other state.
REQ-018 up_ack SHALL equal dn_ack & dn_req, combinationally; up_end SHALL equal dn_end in every state.
REQ-019 IDLE: up_req=1 -> BURST on the next edge, with burst counter bcnt cleared; dn_req stays 0 during that IDLE cycle.
REQ-020 BURST: each up_ack increments the 8-bit bcnt.
REQ-021 BURST limit: burst_len != 0, up_ack=1 and bcnt+1 == burst_len -> DRAIN next edge; throttle_cnt increments, saturating at 255.
REQ-022 BURST: up_req=0 and outstanding==0 -> IDLE; no gap is imposed.
REQ-023 Outstanding: 2-bit counter, +1 on up_ack, -1 on dn_end.
REQ-024 Outstanding: simultaneous up_ack and dn_end leave the counter unchanged.
REQ-025 Outstanding: increment at 3 and decrement at 0 are ignored.
REQ-026 DRAIN: outstanding==0 -> GAP, loading gap counter gcnt with gap_len.
REQ-027 DRAIN: gap_len==0 -> IDLE directly instead of GAP.
REQ-028 GAP: gcnt decrements each cycle; at gcnt==1 -> IDLE, giving exactly gap_len cycles with dn_req=0.
REQ-029 burst_len==0: no DRAIN entry and throttle_cnt never increments.
REQ-030 cfg writes SHALL take effect on the next edge.
REQ-031 A burst_len write during BURST applies to the running burst.
REQ-032 A burst_len write during BURST with new value <= bcnt ends the burst at the next up_ack.
REQ-033 A gap_len write during GAP does not alter the running gcnt.
REQ-034 Writing cfg_sel=2 SHALL clear throttle_cnt; the clear has priority over a same-cycle increment.
REQ-035 Writing cfg_sel=3 SHALL have no effect.
REQ-036 Status read (cfg_sel=3): {state[1:0], outstanding[1:0], 3'b000, up_req}.

Reset
REQ-037 Asserting rst_n low SHALL immediately force state IDLE, bcnt=0, gcnt=0, outstanding=0, throttle_cnt=0, burst_len=BURST_DEF, gap_len=GAP_DEF.
REQ-038 Reset values of the outputs SHALL be dn_req=0, up_ack=0, up_end=0.
REQ-039 Reset mid-burst SHALL drop dn_req combinationally with no drain; dma_access shares rst_n.
REQ-040 rst_n is internal_reset_n, already synchronised by resetter; no extra synchroniser SHALL be added.

Structure
REQ-041 Shared package SHALL hold the state encodings and the cfg_sel codes CFG_BURST=0, CFG_GAP=1, CFG_THR=2, CFG_STAT=3.
REQ-042 Shared package SHALL also hold the BURST_DEF and GAP_DEF default values.
REQ-043 The block SHALL be a single flat module with no sub-module.
REQ-044 Top-level insertion point: between dma_sequencer.dma_req/ack/end and dma_access.

Verification
REQ-045 burst_len=4, gap_len=3, up_req held high, dn_ack every 2nd cycle, dn_end 2 cycles after each ack -> exactly 4 up_acks, DRAIN until the 4th end, 3 cycles of dn_req=0, then a new burst; throttle_cnt=1.
REQ-046 burst_len=0, up_req high for 100 accepts -> dn_req never drops; throttle_cnt=0.
REQ-047 burst_len=8, up_req drops after 3 accepts -> IDLE after the last end with no gap; a re-request is forwarded one cycle after IDLE.
REQ-048 Same-cycle up_ack and dn_end with outstanding=1 -> outstanding stays 1; status read shows it.
REQ-049 rst_n asserted in BURST with outstanding=2 -> dn_req=0 at once; after release, state IDLE, burst_len=16, gap_len=4.
REQ-050 gap_len=0, burst_len=2 -> DRAIN goes straight to IDLE; cfg_sel=2 write in the same cycle as a limit hit -> throttle_cnt reads 0.
